// File: rtl/fetch_ctrl_if.sv
// Instruction-bus handshake between the fetch sequencer and the memory side.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_addr_ok;
  logic              iresp_data_ok;
  logic [31:0]       iresp_data;

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns pc_f, runs one outstanding bus request at
// a time, buffers the returned word for decode and applies redirects, dropping
// any response that belongs to a superseded fetch.
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic              clk,
  input  logic              reset,
  fetch_ctrl_if.master      ibus,
  input  logic              stall_d,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              f_valid,
  output logic [31:0]       f_instr,
  output logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] f_pc_plus4,
  output logic              flush_d
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] buf_pc;
  logic [31:0]       buf_instr;
  logic              redir_pend;
  logic [ADDR_W-1:0] redir_tgt;

  logic              data_rcv;
  logic              discard;
  logic [ADDR_W-1:0] new_tgt;

  // A word lands either on a combined accept+data cycle or later while waiting.
  assign data_rcv = ((state == REQ) & ibus.iresp_addr_ok & ibus.iresp_data_ok) |
                    ((state == WAIT) & ibus.iresp_data_ok);
  // A word is stale if any redirect arrived since (or during) its request.
  assign discard  = redir_pend | redirect_valid;
  // A redirect in the same cycle is newer than the pending one.
  assign new_tgt  = redirect_valid ? redirect_pc : redir_tgt;

  assign ibus.ireq_valid = (state == REQ);
  assign ibus.ireq_addr  = pc_f;

  assign f_valid    = (state == HOLD) & ~redir_pend & ~redirect_valid;
  assign f_instr    = buf_instr;
  assign f_pc       = buf_pc;
  assign f_pc_plus4 = buf_pc + ADDR_W'(4);
  // Reset term keeps D bubbled while reset is held, whatever stall_d says.
  assign flush_d    = reset | redirect_valid | (~f_valid & ~stall_d);

  // Fetch FSM with pc, buffer and pending-redirect bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc_f       <= RESET_PC;
      buf_pc     <= RESET_PC;
      buf_instr  <= '0;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc_f <= redirect_pc;
          state <= REQ;
        end
        REQ, WAIT: begin
          if (data_rcv) begin
            if (discard) begin
              pc_f       <= new_tgt;
              redir_pend <= 1'b0;
              state      <= REQ;
            end else begin
              buf_instr <= ibus.iresp_data;
              buf_pc    <= pc_f;
              state     <= HOLD;
            end
          end else begin
            // Request still in flight: remember the target, finish the fetch.
            if (redirect_valid) begin
              redir_pend <= 1'b1;
              redir_tgt  <= redirect_pc;
            end
            if (state == REQ && ibus.iresp_addr_ok) state <= WAIT;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_f  <= redirect_pc;
            state <= REQ;
          end else if (!stall_d) begin
            pc_f  <= pc_f + ADDR_W'(4);
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: a cycle table covering fetch, split
// handshake, stalls, redirects and pc wrap, then an async reset sequence.
module tb_fetch_ctrl;
  localparam logic [31:0] R = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_d, redirect_valid;
  logic [31:0] redirect_pc;
  logic        f_valid, flush_d;
  logic [31:0] f_instr, f_pc, f_pc_plus4;

  int checks = 0;
  int failures = 0;

  fetch_ctrl_if #(.ADDR_W(32)) ibus();

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(R)) dut (
    .clk(clk), .reset(reset), .ibus(ibus),
    .stall_d(stall_d), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc), .f_pc_plus4(f_pc_plus4),
    .flush_d(flush_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a, d;
    logic [31:0] data;
    logic        st, rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fl;
  } vec_t;

  function automatic vec_t mk(logic a, logic d, logic [31:0] data, logic st, logic rv,
                              logic [31:0] rpc, logic e_req, logic [31:0] e_addr,
                              logic e_fv, logic [31:0] e_instr, logic [31:0] e_pc,
                              logic e_fl);
    vec_t v;
    v.a = a; v.d = d; v.data = data; v.st = st; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic d, input logic [31:0] data,
                       input logic st, input logic rv, input logic [31:0] rpc);
    ibus.iresp_addr_ok = a;
    ibus.iresp_data_ok = d;
    ibus.iresp_data    = data;
    stall_d            = st;
    redirect_valid     = rv;
    redirect_pc        = rpc;
  endtask

  vec_t vecs[$];

  initial begin
    // a  d  data          st rv rpc            req addr          fv instr         pc             flush
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,R,            0,32'h0,       32'h0,        1)); // 0 IDLE
    vecs.push_back(mk(1,1,32'h24080001, 0,0,32'h0,        1,R,            0,32'h0,       32'h0,        1)); // 1 REQ both ok
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,R,            1,32'h24080001,R,            0)); // 2 HOLD consume
    vecs.push_back(mk(1,0,32'h0,        0,0,32'h0,        1,R+4,          0,32'h0,       32'h0,        1)); // 3 addr_ok only
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,R+4,          0,32'h0,       32'h0,        1)); // 4 WAIT
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,        0,R+4,          0,32'h0,       32'h0,        0)); // 5 WAIT stalled
    vecs.push_back(mk(0,1,32'h8c090004, 0,0,32'h0,        0,R+4,          0,32'h0,       32'h0,        1)); // 6 data_ok
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,        0,R+4,          1,32'h8c090004,R+4,          0)); // 7 HOLD stall
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,        0,R+4,          1,32'h8c090004,R+4,          0)); // 8
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,        0,R+4,          1,32'h8c090004,R+4,          0)); // 9
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,R+4,          1,32'h8c090004,R+4,          0)); // 10 stall drops
    vecs.push_back(mk(1,0,32'h0,        0,0,32'h0,        1,R+8,          0,32'h0,       32'h0,        1)); // 11 -> WAIT
    vecs.push_back(mk(0,0,32'h0,        0,1,R+32'h100,    0,R+8,          0,32'h0,       32'h0,        1)); // 12 redirect in WAIT
    vecs.push_back(mk(0,1,32'hdeadbeef, 0,0,32'h0,        0,R+8,          0,32'h0,       32'h0,        1)); // 13 stale data
    vecs.push_back(mk(1,1,32'h11111111, 0,0,32'h0,        1,R+32'h100,    0,32'h0,       32'h0,        1)); // 14 fetch target
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,        0,R+32'h100,    1,32'h11111111,R+32'h100,    0)); // 15 HOLD stall
    vecs.push_back(mk(0,0,32'h0,        1,1,R+32'h200,    0,R+32'h100,    0,32'h0,       32'h0,        1)); // 16 redirect in HOLD
    vecs.push_back(mk(1,1,32'h22222222, 0,1,R+32'h300,    1,R+32'h200,    0,32'h0,       32'h0,        1)); // 17 redirect w/ data
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        1,R+32'h300,    0,32'h0,       32'h0,        1)); // 18 req held
    vecs.push_back(mk(1,1,32'h33333333, 0,0,32'h0,        1,R+32'h300,    0,32'h0,       32'h0,        1)); // 19
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,R+32'h300,    1,32'h33333333,R+32'h300,    0)); // 20
    vecs.push_back(mk(1,0,32'h0,        1,0,32'h0,        1,R+32'h304,    0,32'h0,       32'h0,        0)); // 21 -> WAIT
    vecs.push_back(mk(0,0,32'h0,        0,1,R+32'h400,    0,R+32'h304,    0,32'h0,       32'h0,        1)); // 22 redirect
    vecs.push_back(mk(0,0,32'h0,        0,1,R+32'h500,    0,R+32'h304,    0,32'h0,       32'h0,        1)); // 23 overwrite tgt
    vecs.push_back(mk(0,1,32'h99999999, 0,0,32'h0,        0,R+32'h304,    0,32'h0,       32'h0,        1)); // 24 stale data
    vecs.push_back(mk(1,1,32'h44444444, 0,0,32'h0,        1,R+32'h500,    0,32'h0,       32'h0,        1)); // 25 latest target
    vecs.push_back(mk(0,0,32'h0,        0,1,32'hfffffffc, 0,R+32'h500,    0,32'h0,       32'h0,        1)); // 26 redirect beats consume
    vecs.push_back(mk(1,1,32'h55555555, 0,0,32'h0,        1,32'hfffffffc, 0,32'h0,       32'h0,        1)); // 27
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,32'hfffffffc, 1,32'h55555555,32'hfffffffc, 0)); // 28 plus4 wraps
    vecs.push_back(mk(1,0,32'h0,        0,0,32'h0,        1,32'h0,        0,32'h0,       32'h0,        1)); // 29 pc wrapped, -> WAIT

    reset = 1'b1;
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ireq_valid", ibus.ireq_valid, 0);
    chk("rst_f_valid", f_valid, 0);
    chk("rst_f_instr", f_instr, 0);
    chk("rst_f_pc", f_pc, R);
    chk("rst_f_pc_plus4", f_pc_plus4, R + 4);
    chk("rst_flush_d", flush_d, 1);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.a, v.d, v.data, v.st, v.rv, v.rpc);
      #1;
      chk($sformatf("v%0d_ireq_valid", i), ibus.ireq_valid, v.e_req);
      chk($sformatf("v%0d_ireq_addr", i), ibus.ireq_addr, v.e_addr);
      chk($sformatf("v%0d_f_valid", i), f_valid, v.e_fv);
      chk($sformatf("v%0d_flush_d", i), flush_d, v.e_fl);
      if (v.e_fv) begin
        chk($sformatf("v%0d_f_instr", i), f_instr, v.e_instr);
        chk($sformatf("v%0d_f_pc", i), f_pc, v.e_pc);
        chk($sformatf("v%0d_f_pc_plus4", i), f_pc_plus4, v.e_pc + 32'd4);
      end
      @(negedge clk);
    end

    // Now in WAIT at pc 0: assert reset between edges.
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1 chk("wait_ireq_valid", ibus.ireq_valid, 0);
    #2 reset = 1'b1;
    stall_d = 1'b1;
    #1;
    chk("arst_ireq_valid", ibus.ireq_valid, 0);
    chk("arst_f_valid", f_valid, 0);
    chk("arst_flush_d", flush_d, 1);
    chk("arst_f_pc", f_pc, R);
    chk("arst_f_instr", f_instr, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1, 32'hbadbad00, 0, 0, 32'h0);  // late data_ok from the killed fetch
    #1;
    chk("post_idle_ireq_valid", ibus.ireq_valid, 0);
    chk("post_idle_f_valid", f_valid, 0);
    @(negedge clk);
    #1;
    chk("post_req_ireq_valid", ibus.ireq_valid, 1);
    chk("post_req_ireq_addr", ibus.ireq_addr, R);
    chk("post_req_f_valid", f_valid, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1;
    chk("post_late_f_valid", f_valid, 0);
    chk("post_late_ireq_valid", ibus.ireq_valid, 1);
    chk("post_late_ireq_addr", ibus.ireq_addr, R);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
